// File: rtl/activation_pipe.sv
// ---------------------------------------------------------------------------
// activation_pipe
//   Pipelined activation unit that sits on the output path of the systolic
//   matrix-multiply array. Each accepted row passes through two register
//   stages. Every channel gets the activation selected for the job: bypass,
//   ReLU, leaky ReLU or clipped ReLU. Masked-off channels are forced to zero.
//   The block counts the rows of a job and raises done_activation once the
//   pipeline has drained.
//
// Ports:
//   clk                 clock
//   reset               asynchronous active-low reset
//   enable_activation   job enable (level); drop to abort or to acknowledge done
//   activation_type     0 bypass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU
//   leak_shift          arithmetic right-shift amount used for leaky ReLU
//   num_rows            number of rows in the job
//   in_data_available   inp_data / validity_mask valid this cycle
//   inp_data            row, channel i at [i*DWIDTH +: DWIDTH]
//   validity_mask       bit i = 1 marks channel i valid
//   out_data            activated row, same packing (holds when not valid)
//   out_data_available  out_data valid this cycle
//   done_activation     job complete
// ---------------------------------------------------------------------------
module activation_pipe #(
  parameter int DWIDTH    = 8,
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int CLIP_MAX  = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_activation,
  input  logic [1:0]               activation_type,
  input  logic [2:0]               leak_shift,
  input  logic [CNT_WIDTH-1:0]     num_rows,
  input  logic                     in_data_available,
  input  logic [NUM_CH*DWIDTH-1:0] inp_data,
  input  logic [NUM_CH-1:0]        validity_mask,
  output logic [NUM_CH*DWIDTH-1:0] out_data,
  output logic                     out_data_available,
  output logic                     done_activation
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic signed [DWIDTH-1:0] CLIP_VAL = DWIDTH'(CLIP_MAX);

  logic [1:0]               state_reg, state_next;
  logic [CNT_WIDTH-1:0]     cnt_reg, cnt_next, cnt_plus;

  // Job configuration, frozen for the whole job
  logic [1:0]               act_type_reg;
  logic [2:0]               leak_shift_reg;
  logic [CNT_WIDTH-1:0]     num_rows_reg;

  // Stage 1: raw row
  logic [NUM_CH*DWIDTH-1:0] s1_data_reg;
  logic [NUM_CH-1:0]        s1_mask_reg;
  logic                     s1_valid_reg;

  // Stage 2: activated row (drives the outputs directly)
  logic [NUM_CH*DWIDTH-1:0] s2_data_reg;
  logic                     s2_valid_reg;

  logic                     start_job;
  logic                     abort_job;
  logic                     row_accept;
  logic [NUM_CH*DWIDTH-1:0] act_row;

  assign cnt_plus   = cnt_reg + CNT_WIDTH'(1);
  assign start_job  = (state_reg == ST_IDLE) && enable_activation;
  assign abort_job  = !enable_activation &&
                      ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
  // Once the counter has reached num_rows, further rows are dropped. This
  // also covers num_rows = 0.
  assign row_accept = (state_reg == ST_RUN) && enable_activation &&
                      in_data_available && (cnt_reg != num_rows_reg);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (enable_activation) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        if (!enable_activation) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (row_accept) begin
          cnt_next = cnt_plus;
          if (cnt_plus == num_rows_reg) state_next = ST_DRAIN;
        end else if (cnt_reg == num_rows_reg) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!enable_activation) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (!s1_valid_reg && !s2_valid_reg) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!enable_activation) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-channel activation on stage-1 data, using the latched job mode
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [DWIDTH-1:0] x;
      logic signed [DWIDTH-1:0] y;

      assign x = s1_data_reg[gi*DWIDTH +: DWIDTH];

      always_comb begin
        y = x;
        if (!s1_mask_reg[gi]) begin
          y = '0;
        end else begin
          case (act_type_reg)
            2'd0:    y = x;
            2'd1:    y = x[DWIDTH-1] ? '0 : x;
            // >>> on a signed operand floors toward negative infinity
            2'd2:    y = x[DWIDTH-1] ? (x >>> leak_shift_reg) : x;
            default: y = x[DWIDTH-1] ? '0 : ((x > CLIP_VAL) ? CLIP_VAL : x);
          endcase
        end
      end

      assign act_row[gi*DWIDTH +: DWIDTH] = y;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      act_type_reg   <= '0;
      leak_shift_reg <= '0;
      num_rows_reg   <= '0;
      s1_data_reg    <= '0;
      s1_mask_reg    <= '0;
      s1_valid_reg   <= 1'b0;
      s2_data_reg    <= '0;
      s2_valid_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      if (start_job) begin
        act_type_reg   <= activation_type;
        leak_shift_reg <= leak_shift;
        num_rows_reg   <= num_rows;
      end

      // row_accept is already low on abort, so stage 1 empties by itself
      s1_valid_reg <= row_accept;
      if (row_accept) begin
        s1_data_reg <= inp_data;
        s1_mask_reg <= validity_mask;
      end

      // An abort discards the row sitting in stage 1
      s2_valid_reg <= s1_valid_reg && !abort_job;
      if (s1_valid_reg && !abort_job) s2_data_reg <= act_row;
    end
  end

  assign out_data           = s2_data_reg;
  assign out_data_available = s2_valid_reg;
  assign done_activation    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_activation_pipe.sv
// ---------------------------------------------------------------------------
// tb_activation_pipe
//   Directed bench for activation_pipe. Expected rows are queued when a row is
//   driven. A negedge monitor pops the queue and compares whenever
//   out_data_available is high.
// ---------------------------------------------------------------------------
module tb_activation_pipe;

  localparam int DW   = 8;
  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int CLIP = 96;
  localparam int RW   = DW * NCH;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable_activation = 1'b0;
  logic [1:0]     activation_type = '0;
  logic [2:0]     leak_shift = '0;
  logic [CW-1:0]  num_rows = '0;
  logic           in_data_available = 1'b0;
  logic [RW-1:0]  inp_data = '0;
  logic [NCH-1:0] validity_mask = '0;
  logic [RW-1:0]  out_data;
  logic           out_data_available;
  logic           done_activation;

  always #5 clk = ~clk;

  activation_pipe #(
    .DWIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(CW), .CLIP_MAX(CLIP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable_activation(enable_activation),
    .activation_type(activation_type),
    .leak_shift(leak_shift),
    .num_rows(num_rows),
    .in_data_available(in_data_available),
    .inp_data(inp_data),
    .validity_mask(validity_mask),
    .out_data(out_data),
    .out_data_available(out_data_available),
    .done_activation(done_activation)
  );

  int            checks = 0;
  int            errors = 0;
  int            out_count = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp_row;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    logic [RW-1:0] r;
    r = {c3[DW-1:0], c2[DW-1:0], c1[DW-1:0], c0[DW-1:0]};
    return r;
  endfunction

  // Reference arithmetic on plain integers. Leaky ReLU floors the quotient.
  function automatic logic [RW-1:0] model(input int mode, input int sh,
                                          input logic [RW-1:0] row,
                                          input logic [NCH-1:0] mask);
    logic [RW-1:0] r;
    int x, y;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      x = $signed(row[i*DW +: DW]);
      if (!mask[i])                y = 0;
      else if (mode == 0)          y = x;
      else if (x < 0)              y = (mode == 2) ? -(((-x) + (1 << sh) - 1) / (1 << sh)) : 0;
      else if (mode == 3 && x > CLIP) y = CLIP;
      else                         y = x;
      r[i*DW +: DW] = y[DW-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_data_available === 1'b1) begin
      out_count++;
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_row = exp_q.pop_front();
        chk("out_row", out_data, exp_row);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [RW-1:0] row, input logic [NCH-1:0] mask, input logic avail);
    inp_data          = row;
    validity_mask     = mask;
    in_data_available = avail;
  endtask

  task automatic start_job(input logic [1:0] t, input logic [2:0] s, input logic [CW-1:0] n);
    activation_type   = t;
    leak_shift        = s;
    num_rows          = n;
    in_data_available = 1'b0;
    enable_activation = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (done_activation !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, done_activation, 1);
  endtask

  task automatic end_job(input string tag);
    enable_activation = 1'b0;
    in_data_available = 1'b0;
    tick();
    chk(tag, done_activation, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int acc;
    int iter;
    logic [RW-1:0]  row;
    logic [NCH-1:0] msk;
    int sh;

    // Power-on reset
    #1 reset = 1'b0;
    #2;
    chk("rst_out_avail", out_data_available, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done_activation, 0);
    tick();
    tick();
    #2 reset = 1'b1;
    tick();

    // ReLU, two back-to-back rows, exact latency
    start_job(2'd1, 3'd0, 16'd2);
    drive(pk(-5, 3, 0, 127), 4'hF, 1'b1);
    exp_q.push_back(pk(0, 3, 0, 127));
    tick();
    chk("relu_lat_t0", out_data_available, 0);
    drive(pk(-128, -1, 1, 64), 4'hF, 1'b1);
    exp_q.push_back(pk(0, 0, 1, 64));
    tick();
    chk("relu_lat_t1", out_data_available, 1);
    drive('0, 4'hF, 1'b0);
    tick();
    chk("relu_lat_t2", out_data_available, 1);
    tick();
    chk("relu_lat_t3", out_data_available, 0);
    chk("relu_no_early_done", done_activation, 0);
    wait_done("relu_done", 8);
    tick();
    chk("relu_done_hold", done_activation, 1);
    end_job("relu_done_fall");

    // Leaky ReLU with mask
    start_job(2'd2, 3'd2, 16'd1);
    drive(pk(-8, -7, -1, 20), 4'b1010, 1'b1);
    exp_q.push_back(pk(0, -2, 0, 20));
    tick();
    drive('0, 4'hF, 1'b0);
    wait_done("leaky_done", 8);
    end_job("leaky_done_fall");

    // Clipped ReLU; a mode change mid-job must not take effect
    start_job(2'd3, 3'd0, 16'd1);
    drive(pk(127, 96, -3, 50), 4'hF, 1'b1);
    exp_q.push_back(pk(96, 96, 0, 50));
    tick();
    activation_type = 2'd0;
    drive('0, 4'hF, 1'b0);
    tick();
    chk("clip_out_avail", out_data_available, 1);
    chk("clip_row", out_data, pk(96, 96, 0, 50));
    wait_done("clip_done", 8);
    end_job("clip_done_fall");

    // Row counting with a gap and an overrun
    start_job(2'd1, 3'd0, 16'd3);
    n0 = out_count;
    drive(pk(1, 2, 3, 4), 4'hF, 1'b1);    exp_q.push_back(pk(1, 2, 3, 4));    tick();
    drive('0, 4'hF, 1'b0);                                                     tick();
    drive(pk(5, -6, 7, 8), 4'hF, 1'b1);   exp_q.push_back(pk(5, 0, 7, 8));    tick();
    drive(pk(-9, 10, 11, 12), 4'hF, 1'b1); exp_q.push_back(pk(0, 10, 11, 12)); tick();
    drive(pk(13, 14, 15, 16), 4'hF, 1'b1);                                     tick();
    drive('0, 4'hF, 1'b0);
    wait_done("gap_done", 8);
    chk("gap_out_count", out_count - n0, 3);
    end_job("gap_done_fall");

    // Zero-row job
    start_job(2'd1, 3'd0, 16'd0);
    n0 = out_count;
    drive(pk(1, 1, 1, 1), 4'hF, 1'b1);
    tick();
    drive('0, 4'hF, 1'b0);
    wait_done("zero_done", 8);
    chk("zero_out_count", out_count - n0, 0);
    end_job("zero_done_fall");

    // Abort after two accepted rows
    start_job(2'd1, 3'd0, 16'd5);
    n0 = out_count;
    drive(pk(20, 21, 22, 23), 4'hF, 1'b1);
    exp_q.push_back(pk(20, 21, 22, 23));
    tick();
    drive(pk(30, 31, 32, 33), 4'hF, 1'b1);
    tick();
    chk("abort_row1_avail", out_data_available, 1);
    enable_activation = 1'b0;
    drive('0, 4'hF, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_out", out_data_available, 0);
      chk("abort_no_done", done_activation, 0);
      tick();
    end
    chk("abort_out_count", out_count - n0, 1);
    start_job(2'd0, 3'd0, 16'd1);
    drive(pk(-1, -2, 3, 4), 4'hF, 1'b1);
    exp_q.push_back(pk(-1, -2, 3, 4));
    tick();
    drive('0, 4'hF, 1'b0);
    wait_done("abort_new_done", 8);
    end_job("abort_new_fall");

    // Randomised rows in every mode against the reference model
    for (int m = 0; m < 4; m++) begin
      sh = $urandom_range(0, 7);
      start_job(2'(m), 3'(sh), 16'd4);
      acc = 0;
      iter = 0;
      while (acc < 4 && iter < 40) begin
        if ($urandom_range(0, 3) == 0) begin
          drive('0, 4'hF, 1'b0);
        end else begin
          row = $urandom;
          msk = 4'($urandom_range(0, 15));
          drive(row, msk, 1'b1);
          exp_q.push_back(model(m, sh, row, msk));
          acc++;
        end
        tick();
        iter++;
      end
      drive('0, 4'hF, 1'b0);
      wait_done("rand_done", 10);
      end_job("rand_done_fall");
    end

    // Reset while rows are in flight
    start_job(2'd0, 3'd0, 16'd4);
    drive(pk(1, 2, 3, 4), 4'hF, 1'b1);
    tick();
    drive(pk(5, 6, 7, 8), 4'hF, 1'b1);
    tick();
    chk("rst_mid_inflight", out_data_available, 1);
    chk("rst_mid_data", out_data, pk(1, 2, 3, 4));
    reset = 1'b0;
    enable_activation = 1'b0;
    drive('0, 4'hF, 1'b0);
    #1;
    chk("rst_mid_avail", out_data_available, 0);
    chk("rst_mid_out", out_data, 0);
    chk("rst_mid_done", done_activation, 0);
    tick();
    tick();
    #2 reset = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(pk(9, 9, 9, 9), 4'hF, 1'(i % 2));
      tick();
      chk("idle_no_out", out_data_available, 0);
      chk("idle_no_done", done_activation, 0);
    end

    drive('0, 4'hF, 1'b0);
    tick();
    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/activation_pipe.md
Name: activation_pipe

Overview:
- Parametrised, pipelined activation unit on the output path of the systolic matrix-multiply array.
- Applies a run-time-selected activation function to every channel of each incoming row: bypass, ReLU, leaky ReLU or clipped ReLU.
- Honours the per-channel validity mask.
- Counts the rows of a programmed job and raises a done flag once the pipeline has fully drained.

Parameters:
DWIDTH, 8, bits per channel element (signed two's complement)
NUM_CH, 4, channels per row (matches matrix-multiply size)
CNT_WIDTH, 16, width of the row counter and num_rows
CLIP_MAX, 96, upper clamp for mode 3 (non-negative, fits in DWIDTH-1 bits)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
enable_activation  input  1  job enable; level-sensitive; drop to abort or acknowledge done
activation_type  input  2  0 bypass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU
leak_shift  input  3  arithmetic right-shift amount for mode 2
num_rows  input  CNT_WIDTH  rows in the job
in_data_available  input  1  inp_data/validity_mask valid this cycle
inp_data  input  NUM_CH*DWIDTH  row; channel i at bits [i*DWIDTH +: DWIDTH]
validity_mask  input  NUM_CH  bit i = 1 marks channel i valid
out_data  output  NUM_CH*DWIDTH  activated row, same packing
out_data_available  output  1  out_data valid this cycle
done_activation  output  1  job complete

Behaviour:
- Reset (reset=0, async): FSM to IDLE; row counter, pipeline valids, out_data, out_data_available and done_activation all 0.
- Configuration capture: activation_type, leak_shift and num_rows are latched on the IDLE->RUN edge and held for the whole job; later input changes are ignored until the next job.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE->RUN when enable_activation=1.
  - RUN: each cycle with in_data_available=1 loads stage 1 and increments the row counter. When the counter equals the latched num_rows -> DRAIN; this includes entry with num_rows=0.
  - The cycle that accepts the last row transitions to DRAIN.
  - DRAIN: wait until both pipeline valids are 0 -> DONE.
  - DONE: done_activation=1, held until enable_activation=0 -> IDLE; done_activation returns to 0 in IDLE.
- in_data_available is ignored in IDLE, DRAIN and DONE; extra rows are dropped and not counted.
- Abort: enable_activation=0 in RUN or DRAIN -> IDLE next edge. Both pipeline valids and the counter are cleared, in-flight rows are discarded (out_data_available stays 0), and done_activation never asserts.
- Pipeline, fixed latency 2:
  - Row sampled on edge t (in_data_available=1) gives out_data_available=1 for the cycle after edge t+1.
  - Fully pipelined; back-to-back rows are accepted every cycle, and gaps pass through unchanged.
  - Stage 1 registers data, mask and valid.
  - Stage 2 computes and registers the result and out_data_available.
- out_data holds its last value when out_data_available=0.
- Per-channel arithmetic on signed x:
  - mode 0: y=x.
  - mode 1: y = x<0 ? 0 : x.
  - mode 2: y = x<0 ? (x >>> leak_shift) : x. The shift floors toward negative infinity; leak_shift=0 gives y=x.
  - mode 3: y = x<0 ? 0 : min(x, CLIP_MAX).
  - Mask bit 0 forces y=0 for that channel in every mode.
  - Results are exactly DWIDTH bits; no overflow is possible.

Test Plan:
- Reset and idle: assert reset=0 mid-stream with rows in flight -> all outputs 0 immediately. After release with enable=0, toggling in_data_available -> no out_data_available and no done.
- ReLU: mode 1, num_rows=2, mask 4'b1111. Rows {-5,3,0,127} then {-128,-1,1,64} on consecutive cycles -> {0,3,0,127} then {0,0,1,64}. These appear on the 2 cycles starting 2 cycles after the first input. done_activation rises after the drain and falls the cycle after enable drops.
- Leaky and mask: mode 2, leak_shift=2, mask 4'b1010. Row {-8,-7,-1,20} -> {0,-2,0,20}; masked channels 0 and 2 are 0.
- Clip: mode 3, CLIP_MAX=96. Row {127,96,-3,50} -> {96,96,0,50}. Changing activation_type to 0 mid-job leaves the output unchanged.
- Row counting with gaps and overrun: num_rows=3, inputs on cycles 0, 2, 3, 4 -> exactly 3 outputs; the row on cycle 4 is dropped. num_rows=0 -> done with no output.
- Abort: num_rows=5; drop enable after 2 rows have been accepted -> no further out_data_available and done_activation stays 0. A new job with num_rows=1 then completes normally.
